// File: rtl/sbox_share_arbiter.sv
// Shares one registered 256x8 AES S-box between NUM_REQ word requesters, one byte per cycle.
// Define SBOX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sbox_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int BYTES   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8*BYTES-1:0] req_word,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic [7:0]                 sbox_addr,
  input  logic [7:0]                 sbox_data,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [8*BYTES-1:0]         rsp_word
);

  localparam int WORD_W = 8 * BYTES;
  localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  word_q;
  logic [WORD_W-1:0]  result_q;
  logic [WORD_W-1:0]  assembled;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0] win_onehot;
  logic               any_req;

`ifdef SBOX_ARB_FIXED_PRIO_EN
  always_comb begin
    win_id     = '0;
    win_onehot = '0;
    any_req    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[i]) begin
        any_req       = 1'b1;
        win_id        = ID_W'(i);
        win_onehot[i] = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;
  int              idx;

  // Search from ptr upward, wrapping, so every requester gets a turn within NUM_REQ grants
  always_comb begin
    win_id     = '0;
    win_onehot = '0;
    any_req    = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req         = 1'b1;
        win_id          = ID_W'(idx);
        win_onehot[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (state == IDLE && any_req) begin
      ptr <= (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    sbox_addr  = 8'h00;
    case (state)
      IDLE:  if (any_req) state_next = ISSUE;
      ISSUE: begin
        sbox_addr = word_q[int'(cnt)*8 +: 8];
        if (cnt == CNT_W'(BYTES - 1)) state_next = DRAIN;
      end
      DRAIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The last S-box byte arrives during DRAIN and goes straight into the response
  always_comb begin
    assembled = result_q;
    assembled[WORD_W-1 -: 8] = sbox_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_word  <= '0;
      cnt       <= '0;
      word_q    <= '0;
      result_q  <= '0;
      id_q      <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt    <= win_onehot;
            word_q <= req_word[int'(win_id)*WORD_W +: WORD_W];
            id_q   <= win_id;
            cnt    <= '0;
          end
        end
        ISSUE: begin
          if (cnt != '0) result_q[(int'(cnt)-1)*8 +: 8] <= sbox_data;
          cnt <= cnt + 1'b1;
        end
        DRAIN: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_word  <= assembled;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Randomised and directed bench for sbox_share_arbiter against a transaction-level model
// holding its own AES S-box computed from GF(2^8) arithmetic.
module tb_sbox_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [63:0] req_word;
  logic [1:0]  gnt;
  logic        busy;
  logic [7:0]  sbox_addr;
  logic [7:0]  sbox_data;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_word;

  sbox_share_arbiter #(.NUM_REQ(2), .ID_W(1), .BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_word(req_word), .gnt(gnt), .busy(busy),
    .sbox_addr(sbox_addr), .sbox_data(sbox_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_word(rsp_word)
  );

  logic [7:0] sbox_tab [256];
  int n_checks = 0;
  int n_fail   = 0;

  // Model: age counts cycles since grant (-1 when idle); response due in the cycle after DRAIN
  int          m_age = -1;
  int          m_ptr = 0;
  int          m_id  = 0;
  logic [31:0] m_bytes = '0;
  logic [31:0] m_exp   = '0;
  logic [1:0]  exp_gnt = '0;
  logic        exp_rsp_valid = 1'b0;
  logic [0:0]  exp_rsp_id = '0;
  logic [31:0] exp_rsp_word = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) sbox_data <= sbox_tab[sbox_addr];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] s;
    for (int j = 0; j < 4; j++) s[j*8 +: 8] = sbox_tab[w[j*8 +: 8]];
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic [7:0] exp_addr;
    exp_addr = (m_age >= 0 && m_age < 4) ? m_bytes[m_age*8 +: 8] : 8'h00;
    checkOutput("gnt", 64'(gnt), 64'(exp_gnt));
    checkOutput("busy", 64'(busy), 64'(m_age >= 0));
    checkOutput("sbox_addr", 64'(sbox_addr), 64'(exp_addr));
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_valid));
    checkOutput("rsp_id", 64'(rsp_id), 64'(exp_rsp_id));
    checkOutput("rsp_word", 64'(rsp_word), 64'(exp_rsp_word));
  endtask

  task automatic modelReset();
    m_age = -1; m_ptr = 0; exp_gnt = '0;
    exp_rsp_valid = 1'b0; exp_rsp_id = '0; exp_rsp_word = '0;
  endtask

  // Predict what the next rising edge does with the inputs now applied
  task automatic modelStep(input logic [1:0] r, input logic [63:0] words);
    int w;
    exp_gnt = '0;
    exp_rsp_valid = 1'b0;
    if (m_age < 0) begin
      if (r != 2'b00) begin
`ifdef SBOX_ARB_FIXED_PRIO_EN
        w = r[0] ? 0 : 1;
`else
        w = r[m_ptr] ? m_ptr : (m_ptr + 1) % 2;
`endif
        m_id = w;
        m_bytes = words[w*32 +: 32];
        m_exp = sub_word(m_bytes);
        m_ptr = (w + 1) % 2;
        exp_gnt[w] = 1'b1;
        m_age = 0;
      end
    end else if (m_age == 4) begin
      exp_rsp_valid = 1'b1;
      exp_rsp_id = 1'(m_id);
      exp_rsp_word = m_exp;
      m_age = -1;
    end else begin
      m_age++;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [31:0] w0, input logic [31:0] w1);
    req = r;
    req_word = {w1, w0};
    modelStep(r, {w1, w0});
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_word = '0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    rst_n = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0);

    // Single requester 0, known AES values
    $display("[TB] single request on port 0");
    applyStimulus(2'b01, 32'h5301_00ff, 32'h0);
    checkOutput("t1_gnt", 64'(gnt), 64'h1);
    checkOutput("t1_addr_g", 64'(sbox_addr), 64'hff);
    repeat (5) applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("t1_valid", 64'(rsp_valid), 64'h1);
    checkOutput("t1_word", 64'(rsp_word), 64'hed7c_6316);
    checkOutput("t1_id", 64'(rsp_id), 64'h0);

    // Both requesting continuously
    $display("[TB] both requesting continuously");
    repeat (28) applyStimulus(2'b11, $urandom, $urandom);
    repeat (6) applyStimulus(2'b00, 32'h0, 32'h0);

    // Requester 1 alone with an all-zero word
    applyStimulus(2'b10, 32'h0, 32'h0000_0000);
    repeat (5) applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("t3_id", 64'(rsp_id), 64'h1);
    checkOutput("t3_word", 64'(rsp_word), 64'h6363_6363);

    // Word changes right after grant; latched word must win
    applyStimulus(2'b01, 32'h0101_0101, 32'h0);
    applyStimulus(2'b01, 32'hffff_ffff, 32'h0);
    applyStimulus(2'b00, 32'hffff_ffff, 32'h0);
    repeat (3) applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("t5_word", 64'(rsp_word), 64'h7c7c_7c7c);
    applyStimulus(2'b00, 32'h0, 32'h0);

    // Reset in the middle of ISSUE
    $display("[TB] reset during issue");
    applyStimulus(2'b01, 32'h1234_5678, 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    checkAll();
    rst_n = 1'b1;
    repeat (8) applyStimulus(2'b00, 32'h0, 32'h0);
    applyStimulus(2'b10, 32'h0, 32'hc0ff_ee00);
    repeat (6) applyStimulus(2'b00, 32'h0, 32'h0);

    // Random traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom);
    repeat (8) applyStimulus(2'b00, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
